bus_slave_port: RTL and testbench

- Bit-serial slave endpoint of the ADS serial bus. Sits directly downstream of the address decoder and arbiter.
- Deserialises address and write data from the granted master and writes into a local register-file memory.
- For reads it serialises data back to the master.
- When the attached function reports busy on a read, it issues a split to the arbiter. It signals release when the function is no longer busy.

---
 rtl/ads_bus_pkg.sv | 27 ++
 rtl/serdes_shift.sv | 48 ++++
 rtl/bus_slave_port.sv | 216 +++++++++++++++++++++
 tb/tb_bus_slave_port.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads_bus_pkg.sv
// Shared ADS serial-bus definitions: slave FSM states, default widths and
// read/write encoding used by the slave port, master port and arbiter.
package ads_bus_pkg;

  localparam int ADS_ADDR_W = 6;
  localparam int ADS_DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_SPLIT,
    ST_RESUME
  } slave_state_t;

  // Bit counter width able to hold the longer of the two phase lengths.
  function automatic int bit_cnt_w(input int addr_w, input int data_w);
    int longest;
    longest = (addr_w > data_w) ? addr_w : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/serdes_shift.sv
// LSB-first shift register: serial bits enter at the MSB and leave from the
// LSB, with a parallel load for read data and a last-bit flag driven from the
// caller's bit counter.
module serdes_shift #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             shift_en,
  input  logic             ser_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] par_in,
  input  logic [CNT_W-1:0] bit_cnt,
  output logic [WIDTH-1:0] par_q,
  output logic [WIDTH-1:0] par_next,
  output logic             ser_out,
  output logic             done
);

  logic [WIDTH-1:0] sh_q, sh_d;

  // Next shifter contents: parallel load wins over a shift.
  always_comb begin
    par_next = {ser_in, sh_q[WIDTH-1:1]};
    sh_d     = sh_q;
    if (load_en) begin
      sh_d = par_in;
    end else if (shift_en) begin
      sh_d = par_next;
    end
  end

  // Shifter register, cleared by the port reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign par_q   = sh_q;
  assign ser_out = sh_q[0];
  // Asserted while the counter points at the final bit position of the word.
  assign done    = (bit_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bus_slave_port.sv
// Bit-serial ADS bus slave: shifts in address and write data, writes a local
// register file, serialises read data back, and splits the bus when the
// attached function is busy at the end of a read address phase.
module bus_slave_port
  import ads_bus_pkg::*;
#(
  parameter int ADDR_W   = ADS_ADDR_W,
  parameter int DATA_W   = ADS_DATA_W,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic              rw,
  input  logic              sdata_in,
  input  logic              valid_in,
  input  logic              busy,
  output logic              sdata_out,
  output logic              valid_out,
  output logic              ready,
  output logic              split,
  output logic              split_release,
  output logic [DATA_W-1:0] wdata
);

  localparam int               CNT_W         = bit_cnt_w(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] CNT_ADDR_FULL = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_RD_LAST   = CNT_W'(DATA_W);

  slave_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              split_q, split_d;
  logic              split_release_q, split_release_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              addr_shift, dat_shift, dat_load, mem_we;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              addr_so, addr_done;
  logic [DATA_W-1:0] dat_q, dat_nxt, mem_rdata;
  logic              dat_so, dat_done;
  logic              unused_serdes;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  serdes_shift #(.WIDTH(ADDR_W), .CNT_W(CNT_W)) u_addr_sh (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (addr_shift),
    .ser_in   (sdata_in),
    .load_en  (1'b0),
    .par_in   ('0),
    .bit_cnt  (cnt_q),
    .par_q    (addr_q),
    .par_next (addr_nxt),
    .ser_out  (addr_so),
    .done     (addr_done)
  );

  serdes_shift #(.WIDTH(DATA_W), .CNT_W(CNT_W)) u_data_sh (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (dat_shift),
    .ser_in   (sdata_in),
    .load_en  (dat_load),
    .par_in   (mem_rdata),
    .bit_cnt  (cnt_q),
    .par_q    (dat_q),
    .par_next (dat_nxt),
    .ser_out  (dat_so),
    .done     (dat_done)
  );

  // The address shifter is only read in parallel and the data shifter only
  // serially or via its next value.
  assign unused_serdes = ^{addr_nxt, addr_so, dat_q};

  assign mem_rdata = mem_q[addr_q];

  // Next-state, counter and strobe decode for the transaction FSM.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rw_d            = rw_q;
    split_d         = 1'b0;
    split_release_d = 1'b0;
    wdata_d         = wdata_q;
    addr_shift      = 1'b0;
    dat_shift       = 1'b0;
    dat_load        = 1'b0;
    mem_we          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel && valid_in) begin
          addr_shift = 1'b1;
          rw_d       = rw;
          cnt_d      = CNT_W'(1);
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!sel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ADDR_FULL) begin
          // Address complete, stalled on busy (no-split variant).
          if (!busy) begin
            state_d = ST_RDATA;
            cnt_d   = '0;
          end
        end else if (valid_in) begin
          addr_shift = 1'b1;
          if (addr_done) begin
            cnt_d = '0;
            if (rw_q == RW_WRITE) begin
              state_d = ST_WDATA;
            end else if (!busy) begin
              state_d = ST_RDATA;
            end else if (SPLIT_EN) begin
              state_d = ST_SPLIT;
              split_d = 1'b1;
            end else begin
              cnt_d = CNT_ADDR_FULL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WDATA: begin
        if (!sel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (valid_in) begin
          dat_shift = 1'b1;
          if (dat_done) begin
            mem_we  = 1'b1;
            wdata_d = dat_nxt;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RDATA: begin
        if (!sel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // Turnaround: fetch the word while the bus is quiet.
          dat_load = 1'b1;
          cnt_d    = CNT_W'(1);
        end else begin
          dat_shift = 1'b1;
          if (cnt_q == CNT_RD_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SPLIT: begin
        if (!busy) begin
          split_release_d = 1'b1;
          state_d         = ST_RESUME;
        end
      end
      ST_RESUME: begin
        if (sel) begin
          state_d = ST_RDATA;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and observation registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      rw_q            <= RW_READ;
      split_q         <= 1'b0;
      split_release_q <= 1'b0;
      wdata_q         <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rw_q            <= rw_d;
      split_q         <= split_d;
      split_release_q <= split_release_d;
      wdata_q         <= wdata_d;
    end
  end

  // Register-file write on the edge that captures the last data bit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= dat_nxt;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign valid_out     = (state_q == ST_RDATA) && (cnt_q != '0);
  assign sdata_out     = valid_out & dat_so;
  assign split         = split_q;
  assign split_release = split_release_q;
  assign wdata         = wdata_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Directed bench for bus_slave_port: write, read, split/resume, stalls,
// aborts, back-to-back transfers and reset during a read.
module tb_bus_slave_port;
  import ads_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sel = 1'b0;
  logic       rw = 1'b0;
  logic       sdata_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       busy = 1'b0;
  logic       sdata_out, valid_out, ready, split, split_release;
  logic [7:0] wdata;

  int n_pass = 0;
  int n_total = 0;

  bus_slave_port #(.ADDR_W(6), .DATA_W(8), .SPLIT_EN(1'b1)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .sel           (sel),
    .rw            (rw),
    .sdata_in      (sdata_in),
    .valid_in      (valid_in),
    .busy          (busy),
    .sdata_out     (sdata_out),
    .valid_out     (valid_out),
    .ready         (ready),
    .split         (split),
    .split_release (split_release),
    .wdata         (wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      sdata_in = bits[i];
      valid_in = 1'b1;
      step();
    end
  endtask

  task automatic collect_read(output logic [7:0] word, output int nvalid);
    word = '0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_out === 1'b1) nvalid++;
      word[i] = sdata_out;
    end
  endtask

  task automatic do_read(input logic [5:0] a, output logic [7:0] word,
                         output int nvalid, output logic turn_vo);
    sel = 1'b1;
    rw  = RW_READ;
    shift_bits({10'd0, a}, 6);
    valid_in = 1'b0;
    turn_vo = valid_out;
    collect_read(word, nvalid);
    step();
    sel = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_total++;
    if ({sdata_out, valid_out, ready, split, split_release} !== 5'b00100)
      $display("FAIL reset_outputs: got %b expected %b",
               {sdata_out, valid_out, ready, split, split_release}, 5'b00100);
    else n_pass++;
    n_total++;
    if (wdata !== 8'h00) $display("FAIL reset_wdata: got %h expected %h", wdata, 8'h00);
    else n_pass++;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_write();
    logic [15:0] b;
    b = {2'b00, 8'hA5, 6'h03};
    sel = 1'b1;
    rw  = RW_WRITE;
    shift_bits(b, 13);
    n_total++;
    if (ready !== 1'b0) $display("FAIL write_busy_ready: got %b expected %b", ready, 1'b0);
    else n_pass++;
    n_total++;
    if (wdata !== 8'h00) $display("FAIL write_early: got %h expected %h", wdata, 8'h00);
    else n_pass++;
    shift_bits(b >> 13, 1);
    n_total++;
    if (wdata !== 8'hA5) $display("FAIL write_wdata: got %h expected %h", wdata, 8'hA5);
    else n_pass++;
    n_total++;
    if (ready !== 1'b1) $display("FAIL write_ready_after: got %b expected %b", ready, 1'b1);
    else n_pass++;
    sel = 1'b0;
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_read();
    logic [7:0] word;
    int nvalid;
    sel = 1'b1;
    rw  = RW_READ;
    shift_bits(16'h0003, 6);
    valid_in = 1'b0;
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL read_turnaround: got %b expected %b", valid_out, 1'b0);
    else n_pass++;
    busy = 1'b1;
    collect_read(word, nvalid);
    n_total++;
    if (word !== 8'hA5) $display("FAIL read_data: got %h expected %h", word, 8'hA5);
    else n_pass++;
    n_total++;
    if (nvalid !== 8) $display("FAIL read_valid_cnt: got %0d expected %0d", nvalid, 8);
    else n_pass++;
    step();
    n_total++;
    if ({ready, valid_out, split} !== 3'b100)
      $display("FAIL read_end: got %b expected %b", {ready, valid_out, split}, 3'b100);
    else n_pass++;
    sel = 1'b0;
    busy = 1'b0;
    step();
  endtask

  task automatic test_split();
    logic [7:0] word;
    int nvalid, nrel, nspl;
    sel  = 1'b1;
    rw   = RW_READ;
    busy = 1'b1;
    shift_bits(16'h0003, 6);
    n_total++;
    if ({split, ready} !== 2'b10)
      $display("FAIL split_pulse: got %b expected %b", {split, ready}, 2'b10);
    else n_pass++;
    sel = 1'b0;
    valid_in = 1'b0;
    step();
    n_total++;
    if (split !== 1'b0) $display("FAIL split_one_cycle: got %b expected %b", split, 1'b0);
    else n_pass++;
    nrel = 0;
    nspl = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (split_release === 1'b1) nrel++;
      if (split === 1'b1 || valid_out === 1'b1) nspl++;
    end
    n_total++;
    if ({nrel, nspl} !== {32'd0, 32'd0})
      $display("FAIL split_hold: got release=%0d other=%0d expected 0 0", nrel, nspl);
    else n_pass++;
    busy = 1'b0;
    step();
    n_total++;
    if ({split_release, ready} !== 2'b10)
      $display("FAIL split_release: got %b expected %b", {split_release, ready}, 2'b10);
    else n_pass++;
    step();
    n_total++;
    if ({split_release, ready} !== 2'b00)
      $display("FAIL split_release_once: got %b expected %b", {split_release, ready}, 2'b00);
    else n_pass++;
    sel = 1'b1;
    sdata_in = 1'b1;
    step();
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL resume_turnaround: got %b expected %b", valid_out, 1'b0);
    else n_pass++;
    collect_read(word, nvalid);
    n_total++;
    if (word !== 8'hA5 || nvalid !== 8)
      $display("FAIL resume_data: got %h/%0d expected %h/%0d", word, nvalid, 8'hA5, 8);
    else n_pass++;
    step();
    n_total++;
    if (ready !== 1'b1) $display("FAIL resume_ready: got %b expected %b", ready, 1'b1);
    else n_pass++;
    sel = 1'b0;
    step();
  endtask

  task automatic test_split_min();
    logic [7:0] word;
    int nvalid;
    sel  = 1'b1;
    rw   = RW_READ;
    busy = 1'b1;
    shift_bits(16'h0003, 6);
    busy = 1'b0;
    sel = 1'b0;
    valid_in = 1'b0;
    n_total++;
    if ({split, split_release} !== 2'b10)
      $display("FAIL splitmin_pulse: got %b expected %b", {split, split_release}, 2'b10);
    else n_pass++;
    step();
    n_total++;
    if ({split, split_release} !== 2'b01)
      $display("FAIL splitmin_release: got %b expected %b", {split, split_release}, 2'b01);
    else n_pass++;
    sel = 1'b1;
    step();
    collect_read(word, nvalid);
    n_total++;
    if (word !== 8'hA5 || nvalid !== 8)
      $display("FAIL splitmin_data: got %h/%0d expected %h/%0d", word, nvalid, 8'hA5, 8);
    else n_pass++;
    step();
    sel = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic [15:0] b;
    logic [7:0] word;
    int nvalid;
    logic tv;
    b = {2'b00, 8'h3C, 6'h15};
    sel = 1'b1;
    rw  = RW_WRITE;
    shift_bits(b, 10);
    valid_in = 1'b0;
    repeat (3) step();
    n_total++;
    if ({ready, wdata} !== {1'b0, 8'hA5})
      $display("FAIL stall_hold: got %b/%h expected %b/%h", ready, wdata, 1'b0, 8'hA5);
    else n_pass++;
    shift_bits(b >> 10, 3);
    n_total++;
    if (wdata !== 8'hA5) $display("FAIL stall_early: got %h expected %h", wdata, 8'hA5);
    else n_pass++;
    shift_bits(b >> 13, 1);
    n_total++;
    if (wdata !== 8'h3C) $display("FAIL stall_wdata: got %h expected %h", wdata, 8'h3C);
    else n_pass++;
    sel = 1'b0;
    valid_in = 1'b0;
    step();
    do_read(6'h15, word, nvalid, tv);
    n_total++;
    if (word !== 8'h3C || nvalid !== 8)
      $display("FAIL stall_readback: got %h/%0d expected %h/%0d", word, nvalid, 8'h3C, 8);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] word;
    int nvalid, vo_seen;
    logic tv;
    sel = 1'b1;
    rw  = RW_READ;
    shift_bits(16'h0003, 4);
    sel = 1'b0;
    valid_in = 1'b0;
    vo_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid_out === 1'b1) vo_seen++;
    end
    n_total++;
    if (vo_seen !== 0 || ready !== 1'b1)
      $display("FAIL abort_addr: got valid=%0d ready=%b expected 0 1", vo_seen, ready);
    else n_pass++;
    sel = 1'b1;
    rw  = RW_WRITE;
    shift_bits({2'b00, 8'hFF, 6'h03}, 9);
    sel = 1'b0;
    valid_in = 1'b0;
    step();
    n_total++;
    if ({ready, wdata} !== {1'b1, 8'h3C})
      $display("FAIL abort_wdata: got %b/%h expected %b/%h", ready, wdata, 1'b1, 8'h3C);
    else n_pass++;
    do_read(6'h03, word, nvalid, tv);
    n_total++;
    if (word !== 8'hA5) $display("FAIL abort_mem: got %h expected %h", word, 8'hA5);
    else n_pass++;
    sel = 1'b1;
    rw  = RW_READ;
    shift_bits(16'h0015, 6);
    valid_in = 1'b0;
    repeat (3) step();
    n_total++;
    if (valid_out !== 1'b1) $display("FAIL abort_rd_active: got %b expected %b", valid_out, 1'b1);
    else n_pass++;
    sel = 1'b0;
    step();
    n_total++;
    if ({valid_out, ready} !== 2'b01)
      $display("FAIL abort_rd_drop: got %b expected %b", {valid_out, ready}, 2'b01);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] word;
    int nvalid;
    sel = 1'b1;
    rw  = RW_WRITE;
    shift_bits({2'b00, 8'h5A, 6'h2A}, 14);
    n_total++;
    if (wdata !== 8'h5A) $display("FAIL b2b_wdata: got %h expected %h", wdata, 8'h5A);
    else n_pass++;
    rw = RW_READ;
    shift_bits(16'h002A, 6);
    valid_in = 1'b0;
    n_total++;
    if (valid_out !== 1'b0) $display("FAIL b2b_turnaround: got %b expected %b", valid_out, 1'b0);
    else n_pass++;
    collect_read(word, nvalid);
    n_total++;
    if (word !== 8'h5A || nvalid !== 8)
      $display("FAIL b2b_read: got %h/%0d expected %h/%0d", word, nvalid, 8'h5A, 8);
    else n_pass++;
    step();
    sel = 1'b0;
    step();
  endtask

  task automatic test_reset_rdata();
    logic [7:0] word;
    int nvalid;
    logic tv;
    sel = 1'b1;
    rw  = RW_READ;
    shift_bits(16'h0003, 6);
    valid_in = 1'b0;
    step();
    step();
    n_total++;
    if (valid_out !== 1'b1) $display("FAIL rst_rd_active: got %b expected %b", valid_out, 1'b1);
    else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++;
    if ({valid_out, ready, split, split_release} !== 4'b0100)
      $display("FAIL rst_rd_async: got %b expected %b",
               {valid_out, ready, split, split_release}, 4'b0100);
    else n_pass++;
    n_total++;
    if (wdata !== 8'h00) $display("FAIL rst_rd_wdata: got %h expected %h", wdata, 8'h00);
    else n_pass++;
    sel = 1'b0;
    #1;
    rstn = 1'b1;
    step();
    do_read(6'h03, word, nvalid, tv);
    n_total++;
    if (word !== 8'hA5 || nvalid !== 8 || tv !== 1'b0)
      $display("FAIL rst_rd_readback: got %h/%0d/%b expected %h/%0d/%b",
               word, nvalid, tv, 8'hA5, 8, 1'b0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_split();
    test_split_min();
    test_stall();
    test_abort();
    test_back_to_back();
    test_reset_rdata();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
